// File: rtl/data_memory_pkg.sv
// Shared types and constants for the parametrised data memory and its clear sequencer.
package data_memory_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_t;

   localparam int LANE_WIDTH = 8;

   function automatic int lane_count(input int data_width);
      return data_width / LANE_WIDTH;
   endfunction

endpackage

// File: rtl/data_memory_clear_seq.sv
// Clear sequencer: walks a pointer over every word after reset or a clear request
// and decides whether the array port belongs to the sequencer or to the core.
module data_memory_clear_seq
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   output logic                  busy,
   output logic                  clr_sel,
   output logic                  access_en,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   mem_state_t            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= CLEAR;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      clr_sel    = 1'b0;
      access_en  = 1'b0;
      case (state_reg)
         CLEAR: begin
            clr_sel  = 1'b1;
            ptr_next = ptr_reg + ADDR_WIDTH'(1);
            // The edge that zeroes the last word also hands the array back.
            if (ptr_reg == '1) begin
               state_next = READY;
            end
         end
         READY: begin
            if (clear) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end else begin
               access_en = 1'b1;
            end
         end
         default: begin
            state_next = CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   assign busy     = (state_reg == CLEAR);
   assign clr_addr = ptr_reg;

endmodule

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory: per-byte write enables, write-first registered
// read, and a hardware clear sequence that zeroes the array after reset or on request.
module data_memory_param
   import data_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_WIDTH-1:0]             address,
   input  logic                              Wren,
   input  logic [lane_count(DATA_WIDTH)-1:0] byteEnable,
   input  logic [DATA_WIDTH-1:0]             dataIn,
   input  logic                              clear,
   output logic [DATA_WIDTH-1:0]             dataOut,
   output logic                              busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LANES = lane_count(DATA_WIDTH);

   if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_width_check
      $error("data_memory_param: DATA_WIDTH (%0d) must be a multiple of %0d",
             DATA_WIDTH, LANE_WIDTH);
   end

   logic                  clr_sel;
   logic                  access_en;
   logic [ADDR_WIDTH-1:0] clr_addr;

   data_memory_clear_seq #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear_seq (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .busy     (busy),
      .clr_sel  (clr_sel),
      .access_en(access_en),
      .clr_addr (clr_addr)
   );

   // Each byte lane is its own narrow RAM so a lane write never touches its neighbours.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LANE_WIDTH-1:0] ram [DEPTH];
         logic [LANE_WIDTH-1:0] din_lane;
         logic                  lane_wr;
         logic                  wr_en_next;
         logic [ADDR_WIDTH-1:0] wr_addr_next;
         logic [LANE_WIDTH-1:0] wr_data_next;
         logic [LANE_WIDTH-1:0] rd_data_next;
         logic [LANE_WIDTH-1:0] dout_reg;

         assign din_lane = dataIn[gi*LANE_WIDTH +: LANE_WIDTH];
         assign lane_wr  = access_en && Wren && byteEnable[gi];

         // Array port mux: sequencer zeroes during clear, core writes only when READY.
         always_comb begin
            wr_en_next   = 1'b0;
            wr_addr_next = address;
            wr_data_next = din_lane;
            if (reset) begin
               wr_en_next = 1'b0;
            end else if (clr_sel) begin
               wr_en_next   = 1'b1;
               wr_addr_next = clr_addr;
               wr_data_next = '0;
            end else if (lane_wr) begin
               wr_en_next = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (wr_en_next) begin
               ram[wr_addr_next] <= wr_data_next;
            end
         end

         // Write-first: a lane written this edge returns the new byte.
         always_comb begin
            rd_data_next = '0;
            if (access_en) begin
               rd_data_next = lane_wr ? din_lane : ram[address];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dout_reg <= '0;
            end else begin
               dout_reg <= rd_data_next;
            end
         end

         assign dataOut[gi*LANE_WIDTH +: LANE_WIDTH] = dout_reg;
      end
   endgenerate

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench for data_memory_param: the driver predicts each edge's outcome from
// a word-level reference memory, a separate monitor compares after every edge.
module tb_data_memory_param;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 128;
   localparam int LANES = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] address = '0;
   logic          Wren = 1'b0;
   logic [LANES-1:0] byteEnable = '0;
   logic [DW-1:0] dataIn = '0;
   logic          clear = 1'b0;
   logic [DW-1:0] dataOut;
   logic          busy;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [DW-1:0]    dout;
      logic             bsy;
      logic [AW-1:0]    addr;
      logic             wr;
      logic [LANES-1:0] be;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            clear_left = 0;

   data_memory_param #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .Wren      (Wren),
      .byteEnable(byteEnable),
      .dataIn    (dataIn),
      .clear     (clear),
      .dataOut   (dataOut),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole array reads as zero once a clear has run; accesses are ignored until then.
   task automatic model_clear();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      clear_left = DEPTH;
   endtask

   // Called at a falling edge: drive inputs, predict the next rising edge, wait a cycle.
   task automatic step(input logic wr, input logic [LANES-1:0] be, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic clr);
      exp_t e;
      Wren = wr; byteEnable = be; address = a; dataIn = d; clear = clr;
      e.addr = a; e.wr = wr; e.be = be;
      if (clear_left > 0) begin
         clear_left--;
         e.dout = '0;
         e.bsy  = (clear_left != 0);
      end else if (clr) begin
         model_clear();
         e.dout = '0;
         e.bsy  = 1'b1;
      end else begin
         if (wr) begin
            for (int l = 0; l < LANES; l++) begin
               if (be[l]) ref_mem[a][8*l +: 8] = d[8*l +: 8];
            end
         end
         e.dout = ref_mem[a];
         e.bsy  = 1'b0;
      end
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1; Wren = 1'b1; byteEnable = '1; address = 7'd127;
      dataIn = 32'hDEADBEEF; clear = 1'b0;
      #1;
      check("reset_busy", DW'(busy), DW'(1'b1));
      check("reset_dataOut", dataOut, '0);
      repeat (hold) begin
         @(negedge clk);
         check("reset_busy_hold", DW'(busy), DW'(1'b1));
         check("reset_dataOut_hold", dataOut, '0);
      end
      reset = 1'b0;
      model_clear();
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("busy", DW'(busy), DW'(e.bsy));
            check("dataOut", dataOut, e.dout);
            if (!e.bsy && !busy)
               $display("access addr=%0d wr=%0b be=%b dataOut=%h exp=%h",
                        e.addr, e.wr, e.be, dataOut, e.dout);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin : driver
      @(negedge clk);
      do_reset(3);
      // Writes attempted during the post-reset clear must be dropped.
      repeat (DEPTH) step(1'b1, 4'b1111, 7'd127, 32'hDEADBEEF, 1'b0);
      step(1'b0, 4'b0000, 7'd0,   32'h0, 1'b0);
      step(1'b0, 4'b0000, 7'd1,   32'h0, 1'b0);
      step(1'b0, 4'b0000, 7'd127, 32'h0, 1'b0);
      step(1'b1, 4'b1111, 7'd1, 32'h5A5A5A5A, 1'b0);
      step(1'b1, 4'b1111, 7'd2, 32'hF0F0F0F0, 1'b0);
      step(1'b0, 4'b0000, 7'd1, 32'h0, 1'b0);
      step(1'b0, 4'b0000, 7'd2, 32'h0, 1'b0);
      step(1'b1, 4'b0010, 7'd1, 32'h0000AB00, 1'b0);
      step(1'b0, 4'b0000, 7'd1, 32'h0, 1'b0);
      step(1'b1, 4'b0000, 7'd1, 32'h13572468, 1'b0);
      step(1'b0, 4'b0000, 7'd1, 32'h0, 1'b0);
      step(1'b1, 4'b1111, 7'd3, 32'h12345678, 1'b0);
      step(1'b1, 4'b1111, 7'd5, 32'h55555555, 1'b0);
      // Clear together with a write: clear wins, then a full clear runs.
      step(1'b1, 4'b1111, 7'd5, 32'hCAFEF00D, 1'b1);
      repeat (DEPTH) step(1'b1, 4'($urandom), 7'($urandom), $urandom, 1'($urandom));
      step(1'b0, 4'b0000, 7'd5, 32'h0, 1'b0);
      step(1'b0, 4'b0000, 7'd1, 32'h0, 1'b0);
      // Reset fifty edges into a clear restarts the full sequence.
      step(1'b1, 4'b1111, 7'd9, 32'h99999999, 1'b0);
      step(1'b0, 4'b0000, 7'd0, 32'h0, 1'b1);
      repeat (50) step(1'b0, 4'b0000, 7'd0, 32'h0, 1'b0);
      do_reset(2);
      repeat (DEPTH) step(1'b1, 4'b1111, 7'd9, 32'h77777777, 1'b0);
      step(1'b0, 4'b0000, 7'd9, 32'h0, 1'b0);
      // Random traffic over a small address window to get plenty of read-after-write.
      for (int n = 0; n < 600; n++) begin
         step(1'($urandom), 4'($urandom), 7'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 99) == 0));
      end
      repeat (2) step(1'b0, 4'b0000, 7'd0, 32'h0, 1'b0);
      check("scoreboard_drained", DW'(sb_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_memory_param.md
# data_memory_param

Parametrised single-port data memory for the CPU datapath. It generalises the fixed 8-bit × 128 data memory with configurable word width and depth, per-byte write enables, a registered read port, and a hardware clear sequencer. The clear sequencer zeroes the array after reset or on request. The block sits between the ALU address path and the writeback mux, and `busy` stalls the core while clearing.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 7, word address width; DEPTH = 2**ADDR_WIDTH (derived, not overridable).

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  ADDR_WIDTH  word address for read and write.
- Wren  input  1  write enable.
- byteEnable  input  DATA_WIDTH/8  per-lane write mask; bit i covers dataIn[8i+7:8i].
- dataIn  input  DATA_WIDTH  write data.
- clear  input  1  synchronous request to re-zero the whole array.
- dataOut  output  DATA_WIDTH  registered read data.
- busy  output  1  high while the clear sequence runs; core must stall.

## Operation
- FSM states: CLEAR, READY.
- While reset is high:
  - state = CLEAR, clear pointer = 0, dataOut = 0, busy = 1.
  - No array writes.
- CLEAR state:
  - Each rising edge writes 0 to mem[ptr] and increments ptr.
  - The edge that writes word DEPTH-1 moves the FSM to READY and drives busy to 0.
  - Wren, byteEnable, dataIn, address and clear are ignored; dataOut is held at 0.
- READY state, on each rising edge:
  - If Wren: for each lane i with byteEnable[i]=1, mem[address] lane i <= dataIn lane i; other lanes keep their value.
  - dataOut <= mem[address] after this edge's write (write-first: merged value).
  - Wren=1 with byteEnable all 0 leaves memory unchanged; the read proceeds normally.
  - If clear=1: the write/read on this edge is suppressed, dataOut <= 0, ptr <= 0, state <= CLEAR, busy <= 1.
  - Simultaneous clear and Wren: clear wins; no write occurs.
- Address space: ADDR_WIDTH bits map exactly onto DEPTH words, so there is no out-of-range case.
- Reset asserted mid-clear or mid-access: aborts immediately. The sequence restarts from ptr 0 after release; a full DEPTH cycles is always required.

## Timing
- Read latency: 1 cycle. An address sampled at edge N produces dataOut valid after edge N and held until edge N+1.
- Write: committed at the edge where Wren is sampled high; readable via dataOut at that same edge (write-first).
- Clear duration: exactly DEPTH rising edges after reset deassertion, or after the edge that sampled clear. busy falls after the DEPTH-th edge.
- The first legal access is the first edge with busy=0 sampled low.
- Reset values: dataOut = 0, busy = 1.

## Structure
- Shared package data_memory_pkg holds:
  - the state typedef (CLEAR, READY);
  - the LANE_WIDTH = 8 constant;
  - a function that computes the lane count from DATA_WIDTH.
- Sub-module data_memory_clear_seq owns the FSM, pointer and busy output, and supplies the write address/data/enable mux select.
- The top level holds the array, the per-lane write loop and the dataOut register.
- An elaboration-time check fails if DATA_WIDTH % 8 != 0.

## Test plan
All scenarios use DATA_WIDTH=32 and ADDR_WIDTH=7 (DEPTH=128).
- Reset hold then release:
  - busy high for exactly 128 edges, dataOut=0 throughout.
  - Afterwards, reads of addresses 0, 1 and 127 return 0x00000000.
- Full-word writes and reads:
  - Wren=1, BE=4'b1111: write 0x5A5A5A5A to addr 1 and 0xF0F0F0F0 to addr 2.
  - Wren=0: read addr 1 -> 0x5A5A5A5A, then addr 2 -> 0xF0F0F0F0, each one cycle after the address is applied.
- Partial write:
  - Write addr 1 with BE=4'b0010, dataIn=0x0000AB00 -> subsequent read 0x5A5AAB5A.
  - Write with BE=4'b0000 and any dataIn -> value unchanged.
- Write-first:
  - Write 0x12345678 to addr 3 -> dataOut=0x12345678 after the same edge.
- Writes during busy:
  - During the post-reset clear, drive Wren=1, addr 127, data 0xDEADBEEF -> after busy falls, addr 127 reads 0.
- Clear pulse and reset mid-clear:
  - In READY, pulse clear together with Wren to addr 5 -> no write, busy high for 128 edges, addr 1 reads 0 afterwards.
  - Assert reset 50 cycles into a clear -> on release, busy stays high a full 128 edges.
